// File: rtl/spi_command_dispatcher_if.sv
// Byte-stream / fifo-write bundle between spi_secondary, the command dispatcher and the fifos.
// The master side is the host-facing SPI block plus fifo level reporting; the slave is the dispatcher.
interface spi_command_dispatcher_if #(
   parameter int NumChannels = 4,
   parameter int RecordBytes = 4,
   parameter int FifoDepth   = 16
);
   localparam int LevelW = $clog2(FifoDepth * RecordBytes) + 1;

   logic                          spi_cs;
   logic [7:0]                    rx_byte;
   logic                          rx_valid;
   logic [7:0]                    tx_byte;
   logic [NumChannels*LevelW-1:0] fifo_level;
   logic [NumChannels-1:0]        wr_en;
   logic [7:0]                    wr_data;
   logic [7:0]                    err_flags;

   modport master (
      output spi_cs, rx_byte, rx_valid, fifo_level,
      input  tx_byte, wr_en, wr_data, err_flags
   );

   modport slave (
      input  spi_cs, rx_byte, rx_valid, fifo_level,
      output tx_byte, wr_en, wr_data, err_flags
   );
endinterface

// File: rtl/spi_command_dispatcher.sv
// Decodes one command byte per SPI transaction and routes record bytes into per-channel fifos.
// Optional SPI_CMD_STATS_EN adds per-channel completed-record counters readable with op 4.
module spi_command_dispatcher #(
   parameter int NumChannels = 4,
   parameter int RecordBytes = 4,
   parameter int FifoDepth   = 16
) (
   input logic                     clk,
   input logic                     reset,
   spi_command_dispatcher_if.slave bus
);
   localparam int LevelW   = $clog2(FifoDepth * RecordBytes) + 1;
   localparam int RecShift = $clog2(RecordBytes);
   localparam int ChW      = (NumChannels > 1) ? $clog2(NumChannels) : 1;
   localparam int CntW     = (RecordBytes > 1) ? $clog2(RecordBytes) : 1;
   localparam logic [ChW-1:0]  LastCh   = ChW'(NumChannels - 1);
   localparam logic [CntW-1:0] LastByte = CntW'(RecordBytes - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_STATUS = 3'd1,
      S_WRITE  = 3'd2,
      S_DROP   = 3'd3,
      S_STATS  = 3'd4
   } state_t;

   state_t                 state_q, state_d;
   logic [ChW-1:0]         ch_q, ch_d, idx_q, idx_d;
   logic [CntW-1:0]        cnt_q, cnt_d;
   logic [3:0]             err_q, err_d;
   logic [NumChannels-1:0] wr_en_q, wr_en_d;
   logic [7:0]             wr_data_q, wr_data_d;
   logic [7:0]             tx_q, tx_d;
   logic [7:0]             free_s [NumChannels];
   logic [3:0]             cmd_ch_s, cmd_op_s;
`ifdef SPI_CMD_STATS_EN
   logic                   hi_q, hi_d;
   logic [15:0]            stats_q [NumChannels];
   logic                   rec_done_s, clr_stats_s;
`endif

   // Free record slots; a level beyond capacity reads as no room rather than wrapping.
   function automatic logic [7:0] free_slots(input logic [LevelW-1:0] lvl);
      logic [LevelW-1:0] recs;
      recs = lvl >> RecShift;
      if (recs > LevelW'(FifoDepth)) begin
         return 8'h00;
      end else begin
         return 8'(LevelW'(FifoDepth) - recs);
      end
   endfunction

   assign cmd_ch_s = bus.rx_byte[7:4];
   assign cmd_op_s = bus.rx_byte[3:0];

   always_comb begin
      for (int c = 0; c < NumChannels; c++) begin
         free_s[c] = free_slots(bus.fifo_level[c*LevelW +: LevelW]);
      end
   end

   always_comb begin
      state_d   = state_q;
      ch_d      = ch_q;
      idx_d     = idx_q;
      cnt_d     = cnt_q;
      err_d     = err_q;
      wr_en_d   = {NumChannels{1'b0}};
      wr_data_d = wr_data_q;
      tx_d      = tx_q;
`ifdef SPI_CMD_STATS_EN
      hi_d        = hi_q;
      rec_done_s  = 1'b0;
      clr_stats_s = 1'b0;
`endif
      if (bus.spi_cs) begin
         if ((state_q == S_WRITE) && (cnt_q != CntW'(0))) begin
            err_d[3] = 1'b1;
         end else begin
            err_d[3] = err_q[3];
         end
         state_d = S_IDLE;
         cnt_d   = CntW'(0);
      end else if (bus.rx_valid) begin
         case (state_q)
            S_IDLE: begin
               ch_d = bus.rx_byte[4 +: ChW];
               if ({4'b0000, cmd_ch_s} >= 8'(NumChannels)) begin
                  state_d  = S_DROP;
                  err_d[0] = 1'b1;
               end else begin
                  case (cmd_op_s)
                     4'd0: state_d = S_IDLE;
                     4'd1: begin
                        state_d = S_STATUS;
                        idx_d   = ChW'(0);
                     end
                     4'd2: begin
                        state_d = S_WRITE;
                        cnt_d   = CntW'(0);
                     end
                     4'd3: begin
                        err_d = 4'h0;
`ifdef SPI_CMD_STATS_EN
                        clr_stats_s = 1'b1;
`endif
                     end
`ifdef SPI_CMD_STATS_EN
                     4'd4: begin
                        state_d = S_STATS;
                        hi_d    = 1'b1;
                     end
`endif
                     default: begin
                        state_d  = S_DROP;
                        err_d[1] = 1'b1;
                     end
                  endcase
               end
            end
            S_STATUS: idx_d = (idx_q == LastCh) ? ChW'(0) : idx_q + ChW'(1);
            S_WRITE: begin
               // Room is checked once per record so a record is never split by the check.
               if ((cnt_q == CntW'(0)) && (free_s[ch_q] == 8'h00)) begin
                  state_d  = S_DROP;
                  err_d[2] = 1'b1;
               end else begin
                  wr_en_d[ch_q] = 1'b1;
                  wr_data_d     = bus.rx_byte;
                  cnt_d         = (cnt_q == LastByte) ? CntW'(0) : cnt_q + CntW'(1);
`ifdef SPI_CMD_STATS_EN
                  rec_done_s    = (cnt_q == LastByte);
`endif
               end
            end
`ifdef SPI_CMD_STATS_EN
            S_STATS: hi_d = ~hi_q;
`endif
            S_DROP:  state_d = S_DROP;
            default: state_d = S_IDLE;
         endcase
      end else begin
         state_d = state_q;
      end

      case (state_d)
         S_IDLE:   tx_d = {err_d, (free_s[0] == 8'h00), 3'b000};
         S_STATUS: tx_d = free_s[idx_d];
         S_WRITE:  tx_d = 8'h00;
         S_DROP:   tx_d = 8'hFF;
`ifdef SPI_CMD_STATS_EN
         S_STATS:  tx_d = hi_d ? stats_q[ch_d][15:8] : stats_q[ch_d][7:0];
`endif
         default:  tx_d = 8'hFF;
      endcase
   end

   // State, outputs and counters; reset also cancels a write strobe about to issue.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         ch_q      <= ChW'(0);
         idx_q     <= ChW'(0);
         cnt_q     <= CntW'(0);
         err_q     <= 4'h0;
         wr_en_q   <= {NumChannels{1'b0}};
         wr_data_q <= 8'h00;
         tx_q      <= {4'b0000, (free_s[0] == 8'h00), 3'b000};
`ifdef SPI_CMD_STATS_EN
         hi_q      <= 1'b0;
         for (int c = 0; c < NumChannels; c++) begin
            stats_q[c] <= 16'h0000;
         end
`endif
      end else begin
         state_q   <= state_d;
         ch_q      <= ch_d;
         idx_q     <= idx_d;
         cnt_q     <= cnt_d;
         err_q     <= err_d;
         wr_en_q   <= wr_en_d;
         wr_data_q <= wr_data_d;
         tx_q      <= tx_d;
`ifdef SPI_CMD_STATS_EN
         hi_q      <= hi_d;
         for (int c = 0; c < NumChannels; c++) begin
            if (clr_stats_s) begin
               stats_q[c] <= 16'h0000;
            end else if (rec_done_s && (ch_q == ChW'(c))) begin
               stats_q[c] <= stats_q[c] + 16'h0001;
            end else begin
               stats_q[c] <= stats_q[c];
            end
         end
`endif
      end
   end

   assign bus.tx_byte   = tx_q;
   assign bus.wr_en     = wr_en_q;
   assign bus.wr_data   = wr_data_q;
   assign bus.err_flags = {4'b0000, err_q};
endmodule

// File: tb/tb_spi_command_dispatcher.sv
// Directed bench for spi_command_dispatcher with a transaction-level reference model.
module tb_spi_command_dispatcher;
   localparam int NCH = 4, RB = 4, DEPTH = 16, LW = 7;
`ifdef SPI_CMD_STATS_EN
   localparam bit HasStats = 1'b1;
`else
   localparam bit HasStats = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   spi_command_dispatcher_if #(.NumChannels(NCH), .RecordBytes(RB), .FifoDepth(DEPTH)) bus ();
   spi_command_dispatcher #(.NumChannels(NCH), .RecordBytes(RB), .FifoDepth(DEPTH)) dut (
      .clk(clk), .reset(rst), .bus(bus)
   );

   int n_tests = 0, n_fail = 0;
   bit chk_en = 1'b0;

   // Model: command byte of the open transaction (-1 none), data bytes accepted so far.
   int lv [NCH];
   int m_cmd, m_n, m_stats [NCH];
   bit m_drop;
   logic [3:0] m_err;
   logic [7:0] exp_tx, exp_wd;
   logic [NCH-1:0] exp_we;

   function automatic int free_of(int c);
      int r = lv[c] / RB;
      return (r > DEPTH) ? 0 : DEPTH - r;
   endfunction

   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp_v);
      n_tests++;
      if (act !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got %02h want %02h at %0t", nm, act, exp_v, $time);
      end
   endtask

   task automatic model(input logic r, input logic cs, input logic v, input logic [7:0] b);
      int ch, op;
      exp_we = '0;
      if (r) begin
         m_cmd = -1; m_drop = 0; m_err = 4'h0; m_n = 0;
         for (int c = 0; c < NCH; c++) m_stats[c] = 0;
      end else if (cs) begin
         if (m_cmd >= 0 && (m_cmd & 15) == 2 && !m_drop && (m_n % RB) != 0) m_err[3] = 1'b1;
         m_cmd = -1; m_drop = 0;
      end else if (v) begin
         if (m_cmd < 0) begin
            ch = int'(b) >> 4; op = int'(b) & 15;
            if (ch >= NCH) begin
               m_cmd = int'(b); m_drop = 1; m_err[0] = 1'b1;
            end else if (op == 3) begin
               m_err = 4'h0;
               if (HasStats) for (int c = 0; c < NCH; c++) m_stats[c] = 0;
            end else if (op == 1 || op == 2 || (HasStats && op == 4)) begin
               m_cmd = int'(b); m_n = 0; m_drop = 0;
            end else if (op != 0) begin
               m_cmd = int'(b); m_drop = 1; m_err[1] = 1'b1;
            end
         end else if (!m_drop) begin
            ch = m_cmd >> 4;
            if ((m_cmd & 15) == 2) begin
               if (m_n % RB == 0 && free_of(ch) == 0) begin
                  m_drop = 1; m_err[2] = 1'b1;
               end else begin
                  exp_we[ch] = 1'b1; exp_wd = b; m_n++;
                  if (m_n % RB == 0) m_stats[ch] = (m_stats[ch] + 1) % 65536;
               end
            end else begin
               m_n++;
            end
         end
      end
      if (m_cmd < 0) exp_tx = {m_err, (free_of(0) == 0), 3'b000};
      else if (m_drop) exp_tx = 8'hFF;
      else if ((m_cmd & 15) == 1) exp_tx = 8'(free_of(m_n % NCH));
      else if ((m_cmd & 15) == 2) exp_tx = 8'h00;
      else exp_tx = (m_n % 2 == 0) ? 8'(m_stats[m_cmd >> 4] >> 8) : 8'(m_stats[m_cmd >> 4] & 255);
   endtask

   // Cycle-by-cycle comparison against the model, on the falling edge.
   always @(negedge clk) begin
      if (chk_en) begin
         chk("tx_byte", bus.tx_byte, exp_tx);
         chk("wr_en", {4'b0000, bus.wr_en}, {4'b0000, exp_we});
         if (exp_we != '0) chk("wr_data", bus.wr_data, exp_wd);
         chk("err_flags", bus.err_flags, {4'b0000, m_err});
      end
   end

   task automatic step(input logic r, input logic cs, input logic v, input logic [7:0] b);
      @(negedge clk); #1;
      rst = r; bus.spi_cs = cs; bus.rx_valid = v; bus.rx_byte = b;
      for (int c = 0; c < NCH; c++) bus.fifo_level[c*LW +: LW] = LW'(lv[c]);
      model(r, cs, v, b);
   endtask

   task automatic send(input logic [7:0] b);
      step(1'b0, 1'b0, 1'b1, b);
      step(1'b0, 1'b0, 1'b0, 8'h00);
   endtask

   task automatic deselect();
      step(1'b0, 1'b1, 1'b0, 8'h00);
      step(1'b0, 1'b0, 1'b0, 8'h00);
   endtask

   initial begin
      rst = 1'b1; bus.spi_cs = 1'b1; bus.rx_valid = 1'b0; bus.rx_byte = 8'h00;
      bus.fifo_level = '0;
      for (int c = 0; c < NCH; c++) lv[c] = 0;
      step(1'b1, 1'b1, 1'b0, 8'h00);
      chk_en = 1'b1;
      step(1'b1, 1'b1, 1'b0, 8'h00);
      step(1'b0, 1'b0, 1'b0, 8'h00);
      chk("rst_tx", bus.tx_byte, 8'h00);
      chk("rst_err", bus.err_flags, 8'h00);
      chk("rst_wr_en", {4'b0000, bus.wr_en}, 8'h00);
      chk("rst_wr_data", bus.wr_data, 8'h00);

      // STATUS with distinct levels, including a level beyond capacity
      lv[0] = 0; lv[1] = 8; lv[2] = 64; lv[3] = 100;
      send(8'h01);
      chk("t1_free0", bus.tx_byte, 8'd16);
      send(8'hAA);
      chk("t1_free1", bus.tx_byte, 8'd14);
      send(8'hAA); send(8'hAA);
      chk("t1_free3_clamp", bus.tx_byte, 8'd0);
      send(8'hAA);
      chk("t1_wrap", bus.tx_byte, 8'd16);
      deselect();
      for (int c = 0; c < NCH; c++) lv[c] = 0;

      // two full records to ch2
      send(8'h22);
      for (int i = 0; i < 8; i++) begin
         send(8'hA0 + 8'(i));
         if (i == 0) begin
            chk("t2_we", {4'b0000, bus.wr_en}, 8'h04);
            chk("t2_wd", bus.wr_data, 8'hA0);
         end
      end
      deselect();
      chk("t2_err", bus.err_flags, 8'h00);

      // full fifo on ch1
      lv[1] = 64;
      send(8'h12);
      send(8'h11);
      chk("t3_drop_tx", bus.tx_byte, 8'hFF);
      chk("t3_ovf", bus.err_flags, 8'h04);
      send(8'h12); send(8'h13); send(8'h14);
      deselect();
      chk("t3_idle_tx", bus.tx_byte, 8'h40);
      send(8'h03);
      chk("t3_clear", bus.err_flags, 8'h00);
      deselect();
      lv[1] = 0;

      // partial record then deselect
      send(8'h02); send(8'h55); send(8'h66);
      deselect();
      chk("t4_partial", bus.err_flags, 8'h08);
      chk("t4_idle_tx", bus.tx_byte, 8'h80);
      send(8'h03);
      chk("t4_clear", bus.err_flags, 8'h00);
      deselect();

      // bad channel and unknown opcode
      send(8'h52);
      chk("t5_badch", bus.err_flags, 8'h01);
      chk("t5_tx", bus.tx_byte, 8'hFF);
      deselect();
      send(8'h07);
      chk("t5_badop", bus.err_flags, 8'h03);
      deselect();
      send(8'h03);
      deselect();

      // NO_OP keeps decoding; STATUS starts at channel 0 whatever the channel field
      lv[0] = 12;
      send(8'h00); send(8'h31);
      chk("t6_noop_status", bus.tx_byte, 8'd13);
      deselect();
      lv[0] = 0;

      // three records to ch0, then stats read
      send(8'h02);
      for (int i = 0; i < 12; i++) send(8'(i * 3));
      deselect();
      send(8'h04);
      chk("t7_stats_msb", bus.tx_byte, HasStats ? 8'h00 : 8'hFF);
      send(8'h00);
      chk("t7_stats_lsb", bus.tx_byte, HasStats ? 8'h03 : 8'hFF);
      chk("t7_err", bus.err_flags, HasStats ? 8'h00 : 8'h02);
      deselect();
      send(8'h03);
      deselect();

      // byte with cs high ignored; reset kills an in-flight strobe
      step(1'b0, 1'b1, 1'b1, 8'h01);
      step(1'b0, 1'b0, 1'b0, 8'h00);
      chk("t8_cs_ignored", bus.tx_byte, 8'h00);
      send(8'h02);
      step(1'b1, 1'b0, 1'b1, 8'h5A);
      step(1'b0, 1'b0, 1'b0, 8'h00);
      chk("t8_rst_we", {4'b0000, bus.wr_en}, 8'h00);
      chk("t8_rst_tx", bus.tx_byte, 8'h00);
      step(1'b0, 1'b0, 1'b0, 8'h00);

      chk_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
